// File: rtl/stream_minmax_tracker.sv
// Per-frame min/max/count reduction over a valid/ready sample stream.
// Ports: i_clk, i_rst (sync, active-high); input stream i_in_valid,
//   o_in_ready, i_in_data, i_in_last; result stream o_out_valid,
//   i_out_ready, o_out_min, o_out_max, o_out_count.
// Build option: define MINMAX_SIGNED_EN for two's-complement comparisons.
module stream_minmax_tracker #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_in_data,
    input  logic                 i_in_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [WIDTH-1:0]     o_out_min,
    output logic [WIDTH-1:0]     o_out_max,
    output logic [CNT_WIDTH-1:0] o_out_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_min;
    logic [WIDTH-1:0]     r_max;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     w_min_nxt;
    logic [WIDTH-1:0]     w_max_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_lt;
    logic                 w_gt;
    logic                 w_first;

`ifdef MINMAX_SIGNED_EN
    assign w_lt = $signed(i_in_data) < $signed(r_min);
    assign w_gt = $signed(i_in_data) > $signed(r_max);
`else
    assign w_lt = i_in_data < r_min;
    assign w_gt = i_in_data > r_max;
`endif

    // Gated by reset so the source never sees ready while we clear.
    assign o_in_ready  = !i_rst && (r_state != S_HOLD);
    assign o_out_valid = (r_state == S_HOLD);
    assign w_in_xfer   = i_in_valid && o_in_ready;
    assign w_out_xfer  = o_out_valid && i_out_ready;
    assign w_first     = (r_state == S_IDLE);

    // The first sample of a frame overrides whatever the accumulators hold.
    assign w_min_nxt = (w_first || w_lt) ? i_in_data : r_min;
    assign w_max_nxt = (w_first || w_gt) ? i_in_data : r_max;
    assign w_cnt_nxt = w_first  ? CNT_ONE :
                       (&r_cnt) ? r_cnt   :
                                  r_cnt + CNT_ONE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_in_xfer) begin
                    w_state_nxt = i_in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_in_xfer && i_in_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_out_xfer) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_min       <= '0;
            r_max       <= '0;
            r_cnt       <= '0;
            o_out_min   <= '0;
            o_out_max   <= '0;
            o_out_count <= '0;
        end else if (w_in_xfer) begin
            r_min <= w_min_nxt;
            r_max <= w_max_nxt;
            r_cnt <= w_cnt_nxt;
            // Result includes the last sample itself.
            if (i_in_last) begin
                o_out_min   <= w_min_nxt;
                o_out_max   <= w_max_nxt;
                o_out_count <= w_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Self-checking bench for stream_minmax_tracker.
// Table-driven frames with a result scoreboard plus hand-written corner cases.
module tb_stream_minmax_tracker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_min;
    logic [7:0]  out_max;
    logic [15:0] out_count;

    logic        v2;
    logic        rdy2;
    logic [7:0]  d2;
    logic        l2;
    logic        ov2;
    logic        ordy2;
    logic [7:0]  mn2;
    logic [7:0]  mx2;
    logic [1:0]  cnt2;

    int tests;
    int fails;

    typedef struct {
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int          n;
        logic [7:0]  d [5];
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [15:0] cnt;
    } vec_t;

    exp_t sb [$];
    exp_t e_mon;
    vec_t tv [6];

    stream_minmax_tracker #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_min   (out_min),
        .o_out_max   (out_max),
        .o_out_count (out_count)
    );

    stream_minmax_tracker #(.WIDTH(8), .CNT_WIDTH(2)) u_sat (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (v2),
        .o_in_ready  (rdy2),
        .i_in_data   (d2),
        .i_in_last   (l2),
        .o_out_valid (ov2),
        .i_out_ready (ordy2),
        .o_out_min   (mn2),
        .o_out_max   (mx2),
        .o_out_count (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted result is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("sb_min", {24'd0, out_min}, {24'd0, e_mon.mn});
                chk("sb_max", {24'd0, out_max}, {24'd0, e_mon.mx});
                chk("sb_cnt", {16'd0, out_count}, {16'd0, e_mon.cnt});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the transfer.
    task automatic send(input logic [7:0] d, input logic l);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("sb_drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] mn, input logic [7:0] mx,
                        input logic [15:0] cnt);
        exp_t e;
        e.mn  = mn;
        e.mx  = mx;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic setv(input int i, input int n,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic [7:0] f, input logic [7:0] mn,
                        input logic [7:0] mx, input logic [15:0] cnt);
        tv[i].n    = n;
        tv[i].d[0] = a;
        tv[i].d[1] = b;
        tv[i].d[2] = c;
        tv[i].d[3] = d;
        tv[i].d[4] = f;
        tv[i].mn   = mn;
        tv[i].mx   = mx;
        tv[i].cnt  = cnt;
    endtask

    initial begin
        logic [7:0] s2 [5];
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        v2        = 1'b0;
        d2        = 8'h00;
        l2        = 1'b0;
        ordy2     = 1'b0;

        setv(0, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A, 16'd1);
`ifdef MINMAX_SIGNED_EN
        setv(1, 4, 8'h10, 8'h80, 8'h03, 8'h80, 8'h00, 8'h80, 8'h10, 16'd4);
        setv(3, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 16'd2);
`else
        setv(1, 4, 8'h10, 8'h80, 8'h03, 8'h80, 8'h00, 8'h03, 8'h80, 16'd4);
        setv(3, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 16'd2);
`endif
        setv(2, 3, 8'h44, 8'h44, 8'h44, 8'h00, 8'h00, 8'h44, 8'h44, 16'd3);
        setv(4, 3, 8'h7F, 8'h01, 8'h7E, 8'h00, 8'h00, 8'h01, 8'h7F, 16'd3);
        setv(5, 5, 8'hC0, 8'h90, 8'hA0, 8'hF0, 8'hB0, 8'h90, 8'hF0, 16'd5);

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_min", {24'd0, out_min}, 32'd0);
        chk("rst_out_max", {24'd0, out_max}, 32'd0);
        chk("rst_out_count", {16'd0, out_count}, 32'd0);
        @(posedge clk);
        #1;

        // Single-sample frame: one-cycle out_valid pulse
        push(8'h5A, 8'h5A, 16'd1);
        send(8'h5A, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pulse_hi", {31'd0, out_valid}, 32'd1);
        chk("pulse_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("pulse_lo", {31'd0, out_valid}, 32'd0);
        drain();

        // Table of back-to-back frames
        for (int i = 0; i < 6; i++) begin
            push(tv[i].mn, tv[i].mx, tv[i].cnt);
            for (int j = 0; j < tv[i].n; j++) begin
                send(tv[i].d[j], (j == tv[i].n - 1));
            end
        end
        in_valid = 1'b0;
        drain();

        // Back-pressure with a pending sample
        out_ready = 1'b0;
        push(8'h11, 8'h22, 16'd2);
        send(8'h22, 1'b0);
        send(8'h11, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_min", {24'd0, out_min}, 32'h11);
            chk("bp_max", {24'd0, out_max}, 32'h22);
            chk("bp_cnt", {16'd0, out_count}, 32'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        push(8'h33, 8'h44, 16'd2);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(8'h44, 1'b1);
        in_valid = 1'b0;
        drain();

        // Reset mid-frame discards the partial result
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_valid2", {31'd0, out_valid}, 32'd0);
        chk("mid_count", {16'd0, out_count}, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        push(8'h07, 8'h07, 16'd1);
        send(8'h07, 1'b1);
        in_valid = 1'b0;
        drain();

        // Count saturation on the narrow-counter instance
        s2[0] = 8'd1;
        s2[1] = 8'd2;
        s2[2] = 8'd3;
        s2[3] = 8'd4;
        s2[4] = 8'd0;
        for (int i = 0; i < 5; i++) begin
            v2 = 1'b1;
            d2 = s2[i];
            l2 = (i == 4);
            @(negedge clk);
            chk("sat_ready", {31'd0, rdy2}, 32'd1);
            @(posedge clk);
            #1;
        end
        v2 = 1'b0;
        l2 = 1'b0;
        @(negedge clk);
        chk("sat_valid", {31'd0, ov2}, 32'd1);
        chk("sat_cnt", {30'd0, cnt2}, 32'd3);
        chk("sat_min", {24'd0, mn2}, 32'd0);
        chk("sat_max", {24'd0, mx2}, 32'd4);
        @(posedge clk);
        #1;
        ordy2 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat_valid_done", {31'd0, ov2}, 32'd0);
        chk("sat_cnt_kept", {30'd0, cnt2}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
